// File: rtl/hpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hpu_ctrl_pkg
// Brief   : State encodings, register word indices and CTRL bit positions
//           shared by the HDC run sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package hpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } hv_state_e;

  localparam logic [2:0] c_REG_CTRL     = 3'd0;
  localparam logic [2:0] c_REG_STATUS   = 3'd1;
  localparam logic [2:0] c_REG_IN_LEN   = 3'd2;
  localparam logic [2:0] c_REG_OUT_LEN  = 3'd3;
  localparam logic [2:0] c_REG_IN_CNT   = 3'd4;
  localparam logic [2:0] c_REG_OUT_CNT  = 3'd5;
  localparam logic [2:0] c_REG_TO_LIMIT = 3'd6;

  localparam int c_CTRL_START_COM = 0;
  localparam int c_CTRL_START_RUN = 1;
  localparam int c_CTRL_ABORT     = 2;
  localparam int c_CTRL_IRQ_CLR   = 3;

  function automatic logic is_busy(input hv_state_e s);
    return (s == ST_LOAD) || (s == ST_EXEC) || (s == ST_DRAIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hv_run_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : hv_watchdog
// Brief   : Saturating idle-cycle counter; pulses expire on the cycle whose
//           count equals a nonzero limit.
// Revision: 1.0 - initial release
// ============================================================================
module hv_watchdog #(
  parameter int TO_W = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            clear,
  input  logic [TO_W-1:0] limit,
  output logic            expire
);

  logic [TO_W-1:0] r_cnt;
  logic [TO_W:0]   w_cnt_p1;

  // r_cnt holds completed idle cycles, so the current cycle is number r_cnt+1
  assign w_cnt_p1 = {1'b0, r_cnt} + {{TO_W{1'b0}}, 1'b1};
  assign expire   = enable && !clear && (limit != '0) && (w_cnt_p1 == {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || clear) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= w_cnt_p1[TO_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/hv_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : hv_run_sequencer
// Brief   : Job sequencer for the HDC accelerator: prepare/execute phases,
//           beat counting, watchdog, status registers and level interrupt.
// Revision: 1.0 - initial release
// ============================================================================
module hv_run_sequencer
  import hpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int TO_W  = 20
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESETN,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  input  logic        in_valid,
  input  logic        in_ready,
  input  logic        in_last,
  input  logic        out_valid,
  input  logic        out_ready,
  input  logic        out_last,
  output logic        com,
  output logic        run,
  output logic        busy,
  output logic        irq
);

  hv_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_in_len, r_out_len, r_in_cnt, r_out_cnt;
  logic [CNT_W-1:0] w_in_cnt_nxt, w_out_cnt_nxt, w_in_cnt_inc, w_out_cnt_inc;
  logic [TO_W-1:0]  r_to_limit;
  logic             r_done, r_err_len, r_err_to, r_irq, r_com, r_run, r_busy;
  logic             w_done_nxt, w_err_len_nxt, w_err_to_nxt, w_irq_set;
  logic             w_in_hs, w_out_hs, w_wr_ctrl, w_start, w_abort, w_irq_clr;
  logic             w_idle_like, w_wd_expire, w_unused_wdata;

  assign w_in_hs     = in_valid & in_ready;
  assign w_out_hs    = out_valid & out_ready;
  assign w_wr_ctrl   = reg_we && (reg_addr == c_REG_CTRL);
  assign w_abort     = w_wr_ctrl && reg_wdata[c_CTRL_ABORT];
  assign w_irq_clr   = w_wr_ctrl && reg_wdata[c_CTRL_IRQ_CLR];
  assign w_idle_like = !is_busy(r_state);
  assign w_start     = w_wr_ctrl && !reg_wdata[c_CTRL_ABORT] && w_idle_like &&
                       (reg_wdata[c_CTRL_START_COM] || reg_wdata[c_CTRL_START_RUN]);
  assign w_unused_wdata = ^reg_wdata;

  assign w_in_cnt_inc  = (r_in_cnt  == '1) ? r_in_cnt  : r_in_cnt  + CNT_W'(1);
  assign w_out_cnt_inc = (r_out_cnt == '1) ? r_out_cnt : r_out_cnt + CNT_W'(1);

  // Idle-like states hold the watchdog at zero, which also gives a fresh count at start
  hv_watchdog #(.TO_W(TO_W)) u_watchdog (
    .clk    (AXIS_ACLK),
    .rst_n  (AXIS_ARESETN),
    .enable (r_busy),
    .clear  (w_in_hs | w_out_hs),
    .limit  (r_to_limit),
    .expire (w_wd_expire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_in_cnt_nxt  = r_in_cnt;
    w_out_cnt_nxt = r_out_cnt;
    w_done_nxt    = r_done;
    w_err_len_nxt = r_err_len;
    w_err_to_nxt  = r_err_to;
    w_irq_set     = 1'b0;
    if (w_start) begin
      w_in_cnt_nxt  = '0;
      w_out_cnt_nxt = '0;
      w_done_nxt    = 1'b0;
      w_err_len_nxt = 1'b0;
      w_err_to_nxt  = 1'b0;
      if (r_in_len == '0) begin
        w_state_nxt   = ST_ERR;
        w_err_len_nxt = 1'b1;
        w_irq_set     = 1'b1;
      end else if (reg_wdata[c_CTRL_START_RUN]) begin
        w_state_nxt = ST_EXEC;
      end else begin
        w_state_nxt = ST_LOAD;
      end
    end else begin
      case (r_state)
        ST_LOAD, ST_EXEC: begin
          if (w_in_hs) begin
            w_in_cnt_nxt = w_in_cnt_inc;
            if (in_last && (w_in_cnt_inc != r_in_len)) w_err_len_nxt = 1'b1;
            if (w_in_cnt_inc == r_in_len) begin
              if (r_state == ST_LOAD) begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
                w_irq_set   = 1'b1;
              end else begin
                w_state_nxt = ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_in_hs) w_err_len_nxt = 1'b1;
          if (w_out_hs) begin
            w_out_cnt_nxt = w_out_cnt_inc;
            if (out_last) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
              w_irq_set   = 1'b1;
              if (w_out_cnt_inc != r_out_len) w_err_len_nxt = 1'b1;
            end
          end
        end
        default: ;
      endcase
      // Expiry overrides a completion landing on the same cycle
      if (w_wd_expire) begin
        w_state_nxt  = ST_ERR;
        w_err_to_nxt = 1'b1;
        w_done_nxt   = r_done;
        w_irq_set    = 1'b1;
      end
    end
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = r_done;
      w_irq_set   = 1'b0;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_state    <= ST_IDLE;
      r_in_len   <= '0;
      r_out_len  <= '0;
      r_to_limit <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_done     <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_to   <= 1'b0;
      r_irq      <= 1'b0;
      r_com      <= 1'b0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_cnt  <= w_in_cnt_nxt;
      r_out_cnt <= w_out_cnt_nxt;
      r_done    <= w_done_nxt;
      r_err_len <= w_err_len_nxt;
      r_err_to  <= w_err_to_nxt;
      r_irq     <= w_irq_set | (r_irq & ~w_irq_clr);
      r_com     <= (w_state_nxt == ST_LOAD);
      r_run     <= (w_state_nxt == ST_EXEC) || (w_state_nxt == ST_DRAIN);
      r_busy    <= is_busy(w_state_nxt);
      if (reg_we && !r_busy) begin
        case (reg_addr)
          c_REG_IN_LEN:   r_in_len   <= reg_wdata[CNT_W-1:0];
          c_REG_OUT_LEN:  r_out_len  <= reg_wdata[CNT_W-1:0];
          c_REG_TO_LIMIT: r_to_limit <= reg_wdata[TO_W-1:0];
          default: ;
        endcase
      end
      reg_rvalid <= reg_re;
      if (reg_re) begin
        case (reg_addr)
          c_REG_STATUS:   reg_rdata <= {26'b0, r_state, r_err_to, r_err_len, r_done};
          c_REG_IN_LEN:   reg_rdata <= 32'(r_in_len);
          c_REG_OUT_LEN:  reg_rdata <= 32'(r_out_len);
          c_REG_IN_CNT:   reg_rdata <= 32'(r_in_cnt);
          c_REG_OUT_CNT:  reg_rdata <= 32'(r_out_cnt);
          c_REG_TO_LIMIT: reg_rdata <= 32'(r_to_limit);
          default:        reg_rdata <= '0;
        endcase
      end
    end
  end

  assign com  = r_com;
  assign run  = r_run;
  assign busy = r_busy;
  assign irq  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_hv_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_hv_run_sequencer
// Brief   : Self-checking bench: directed job scenarios plus randomized jobs
//           whose outcome is predicted from the job parameters.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hv_run_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_we = 1'b0, reg_re = 1'b0;
  logic [2:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        in_valid = 1'b0, in_ready = 1'b0, in_last = 1'b0;
  logic        out_valid = 1'b0, out_ready = 1'b0, out_last = 1'b0;
  logic        com, run, busy, irq;

  int n_total = 0;
  int n_bad   = 0;

  hv_run_sequencer #(.CNT_W(16), .TO_W(20)) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .reg_rvalid   (reg_rvalid),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .com          (com),
    .run          (run),
    .busy         (busy),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    reg_re = 1'b1; reg_addr = a;
    tick();
    d = reg_rdata;
    chk("rvalid", {31'b0, reg_rvalid}, 32'd1);
    reg_re = 1'b0;
  endtask

  // Stall cycles alternate between valid-without-ready and ready-without-valid
  task automatic in_beat(input logic last, input int gap);
    repeat (gap) begin
      if ($urandom % 2) begin in_valid = 1'b1; in_ready = 1'b0; end
      else begin in_valid = 1'b0; in_ready = 1'b1; end
      tick();
    end
    in_valid = 1'b1; in_ready = 1'b1; in_last = last;
    tick();
    in_valid = 1'b0; in_ready = 1'b0; in_last = 1'b0;
  endtask

  task automatic out_beat(input logic last, input int gap);
    repeat (gap) begin
      if ($urandom % 2) begin out_valid = 1'b1; out_ready = 1'b0; end
      else begin out_valid = 1'b0; out_ready = 1'b1; end
      tick();
    end
    out_valid = 1'b1; out_ready = 1'b1; out_last = last;
    tick();
    out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
  endtask

  // One complete job; lastpos=0 means no in_last, k = out beat carrying out_last
  task automatic run_job(input bit exec, input int l, input int m, input int lastpos,
                         input int k, input bit stray);
    logic [31:0] d;
    bit exp_err;
    exp_err = (lastpos != 0 && lastpos != l) || (exec && (k != m || stray));
    reg_write(3'd0, 32'h8);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    reg_write(3'd2, l);
    reg_write(3'd3, m);
    reg_write(3'd0, exec ? 32'h2 : 32'h1);
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_com", {31'b0, com}, {31'b0, !exec});
    chk("start_run", {31'b0, run}, {31'b0, exec});
    for (int i = 1; i <= l; i++) begin
      in_beat(i == lastpos, $urandom_range(0, 3));
      if (i < l) begin
        chk("phase_com", {31'b0, com}, {31'b0, !exec});
        chk("phase_run", {31'b0, run}, {31'b0, exec});
      end
    end
    if (!exec) begin
      chk("load_end_com", {31'b0, com}, 32'd0);
      chk("load_end_busy", {31'b0, busy}, 32'd0);
    end else begin
      chk("drain_run", {31'b0, run}, 32'd1);
      chk("drain_com", {31'b0, com}, 32'd0);
      if (stray) in_beat(1'b0, $urandom_range(0, 3));
      for (int j = 1; j <= k; j++) begin
        out_beat(j == k, $urandom_range(0, 3));
        if (j < k) chk("drain_run_mid", {31'b0, run}, 32'd1);
      end
      chk("exec_end_run", {31'b0, run}, 32'd0);
      chk("exec_end_busy", {31'b0, busy}, 32'd0);
    end
    chk("end_irq", {31'b0, irq}, 32'd1);
    reg_read(3'd1, d);
    chk("status", d, 32'h21 | (32'(exp_err) << 1));
    reg_read(3'd4, d);
    chk("in_cnt", d, l);
    reg_read(3'd5, d);
    chk("out_cnt", d, exec ? k : 0);
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_com", {31'b0, com}, 32'd0);
    chk("rst_run", {31'b0, run}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    reg_read(3'd1, d);
    chk("rst_status", d, 32'd0);
    reg_read(3'd2, d);
    chk("rst_in_len", d, 32'd0);

    reg_write(3'd6, 32'd8);
    run_job(1'b0, 4, 0, 4, 0, 1'b0);
    run_job(1'b1, 3, 32, 3, 32, 1'b0);

    // Watchdog with no traffic: ERR after exactly TO_LIMIT busy cycles
    reg_write(3'd6, 32'd100);
    reg_write(3'd2, 32'd3);
    reg_write(3'd0, 32'h2);
    chk("wd_start_run", {31'b0, run}, 32'd1);
    repeat (99) tick();
    chk("wd_pre_run", {31'b0, run}, 32'd1);
    tick();
    chk("wd_run", {31'b0, run}, 32'd0);
    chk("wd_irq", {31'b0, irq}, 32'd1);
    reg_read(3'd1, d);
    chk("wd_status", d, 32'h2C);
    reg_write(3'd0, 32'h8);
    chk("wd_irq_clr", {31'b0, irq}, 32'd0);
    reg_write(3'd6, 32'd1);
    reg_write(3'd0, 32'h2);
    chk("wd1_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("wd1_busy_end", {31'b0, busy}, 32'd0);
    reg_read(3'd1, d);
    chk("wd1_status", d, 32'h2C);
    reg_write(3'd6, 32'd8);

    // Early in_last then abort
    reg_write(3'd2, 32'd5);
    reg_write(3'd0, 32'h2);
    in_beat(1'b0, 0);
    in_beat(1'b1, 0);
    reg_read(3'd1, d);
    chk("early_last_status", d, 32'h12);
    in_beat(1'b0, 0);
    reg_write(3'd0, 32'h4);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_run", {31'b0, run}, 32'd0);
    reg_read(3'd4, d);
    chk("abort_in_cnt", d, 32'd3);
    reg_read(3'd1, d);
    chk("abort_status", d, 32'h02);
    tick();
    chk("rdata_hold", reg_rdata, 32'h02);
    chk("rvalid_pulse", {31'b0, reg_rvalid}, 32'd0);

    // Abort beats start; start and length writes ignored while busy; zero length
    reg_write(3'd0, 32'h6);
    chk("abort_start_busy", {31'b0, busy}, 32'd0);
    reg_read(3'd1, d);
    chk("abort_start_status", d, 32'h02);
    reg_write(3'd0, 32'h2);
    chk("restart_run", {31'b0, run}, 32'd1);
    in_beat(1'b0, 0);
    reg_write(3'd2, 32'd9);
    reg_write(3'd0, 32'h2);
    reg_read(3'd4, d);
    chk("busy_start_in_cnt", d, 32'd1);
    reg_read(3'd1, d);
    chk("busy_start_status", d, 32'h10);
    reg_write(3'd0, 32'h4);
    reg_read(3'd2, d);
    chk("busy_len_write", d, 32'd5);
    reg_write(3'd2, 32'd0);
    reg_write(3'd0, 32'h2);
    chk("zero_len_busy", {31'b0, busy}, 32'd0);
    chk("zero_len_run", {31'b0, run}, 32'd0);
    chk("zero_len_irq", {31'b0, irq}, 32'd1);
    reg_read(3'd1, d);
    chk("zero_len_status", d, 32'h2A);

    for (int n = 0; n < 12; n++) begin
      bit  exec;
      int  l, m, lp, k;
      bit  stray;
      exec  = 1'($urandom % 2);
      l     = $urandom_range(1, 6);
      m     = $urandom_range(1, 6);
      lp    = $urandom_range(0, l);
      k     = (exec && ($urandom % 3 == 0)) ? $urandom_range(1, 7) : (exec ? m : 0);
      stray = exec && ($urandom % 5 == 0);
      run_job(exec, l, m, lp, k, stray);
    end

    // Asynchronous reset mid-DRAIN, asserted away from any clock edge
    reg_write(3'd0, 32'h8);
    reg_write(3'd2, 32'd1);
    reg_write(3'd3, 32'd4);
    reg_write(3'd6, 32'd0);
    reg_write(3'd2, 32'd0);
    reg_write(3'd0, 32'h2);
    reg_write(3'd2, 32'd1);
    reg_write(3'd0, 32'h2);
    in_beat(1'b0, 0);
    chk("pre_rst_run", {31'b0, run}, 32'd1);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    chk("pre_rst_irq", {31'b0, irq}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_com", {31'b0, com}, 32'd0);
    chk("arst_run", {31'b0, run}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      reg_read(3'(a), d);
      chk($sformatf("arst_reg%0d", a), d, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
